// File: rtl/fb_mem_arbiter.sv
// Framebuffer RAM arbiter: display read bursts take priority over single-word draw writes.
// Define FB_ARB_STARVE_GUARD_EN to build the writer starvation guard.
module fb_mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int BURST_LEN  = 8,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 64
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_rd_ack,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    output logic              o_rd_last,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ack,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_busy
);

    // state | meaning
    // IDLE  | arbitrate between display read and draw write
    // RD    | issue one burst read per cycle, BURST_LEN cycles
    // WR    | issue the latched single-word write
    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    if (BURST_LEN < 1 || RD_LAT < 1 || STARVE_MAX < 1) begin : g_param_err
        $error("fb_mem_arbiter: BURST_LEN, RD_LAT and STARVE_MAX must be >= 1");
    end

    state_t              r_state;
    state_t              w_next_state;
    logic [BEAT_W-1:0]   r_beat;
    logic [ADDR_W-1:0]   r_base;
    logic                r_rd_ack;
    logic                r_wr_ack;
    logic                r_mem_en;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_issue_last;
    logic [RD_LAT-1:0]   r_vpipe;
    logic [RD_LAT-1:0]   r_lpipe;
    logic                w_force;

`ifdef FB_ARB_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    logic [STARVE_W-1:0] r_starve;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_starve <= '0;
        end else if (r_state == IDLE && w_next_state == WR) begin
            r_starve <= '0;
        end else if (i_wr_req && r_state != WR && r_starve != STARVE_W'(STARVE_MAX)) begin
            r_starve <= r_starve + STARVE_W'(1);
        end
    end

    assign w_force = i_wr_req && (r_starve >= STARVE_W'(STARVE_MAX));
`else
    assign w_force = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (i_rd_req && !w_force) begin
                    w_next_state = RD;
                end else if (i_wr_req) begin
                    w_next_state = WR;
                end
            end
            RD:      if (r_beat == LAST_BEAT) w_next_state = IDLE;
            WR:      w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_beat       <= '0;
            r_base       <= '0;
            r_rd_ack     <= 1'b0;
            r_wr_ack     <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_issue_last <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_rd_ack     <= 1'b0;
            r_wr_ack     <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_issue_last <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_next_state == RD) begin
                        r_base   <= i_rd_addr;
                        r_beat   <= '0;
                        r_rd_ack <= 1'b1;
                    end
                end
                RD: begin
                    // base + beat wraps naturally at the ADDR_W boundary
                    r_mem_en     <= 1'b1;
                    r_mem_addr   <= r_base + ADDR_W'(r_beat);
                    r_issue_last <= (r_beat == LAST_BEAT);
                    r_beat       <= r_beat + BEAT_W'(1);
                end
                WR: begin
                    r_mem_en    <= 1'b1;
                    r_mem_we    <= 1'b1;
                    r_mem_addr  <= i_wr_addr;
                    r_mem_wdata <= i_wr_data;
                    r_wr_ack    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Return flags travel alongside the RAM latency, independent of the FSM.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vpipe <= '0;
            r_lpipe <= '0;
        end else begin
            r_vpipe[0] <= r_mem_en & ~r_mem_we;
            r_lpipe[0] <= r_issue_last;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
                r_lpipe[i] <= r_lpipe[i-1];
            end
        end
    end

    assign o_rd_ack    = r_rd_ack;
    assign o_wr_ack    = r_wr_ack;
    assign o_mem_en    = r_mem_en;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_rd_valid  = r_vpipe[RD_LAT-1];
    assign o_rd_last   = r_lpipe[RD_LAT-1];
    assign o_rd_data   = r_vpipe[RD_LAT-1] ? i_mem_rdata : '0;
    assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Directed bench for fb_mem_arbiter with a behavioural single-port RAM (read latency 1).
// Guard-specific starvation checks follow FB_ARB_STARVE_GUARD_EN.
module tb_fb_mem_arbiter;

    localparam int BL = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_req = 1'b0;
    logic [15:0] rd_addr = '0;
    logic        rd_ack, rd_valid, rd_last;
    logic [15:0] rd_data;
    logic        wr_req = 1'b0;
    logic [15:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        wr_ack, mem_en, mem_we, busy;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;

    logic [15:0] ram     [0:65535];
    logic [15:0] exp_mem [0:65535];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        do_rd;
        logic [15:0] rd_a;
        logic        do_wr;
        logic [15:0] wr_a;
        logic [15:0] wr_d;
        int          exp_rd_ack;
        int          exp_wr_ack;
    } vec_t;
    vec_t vecs [5];

    fb_mem_arbiter dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_ack(rd_ack),
        .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_rd_last(rd_last),
        .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ack(wr_ack),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata), .o_busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int rd_ack_cyc = 0, wr_ack_cyc = 0, n_iss = 0, n_val = 0, n_wr = 0;
        logic [15:0] a;
        rd_req = v.do_rd; rd_addr = v.rd_a;
        wr_req = v.do_wr; wr_addr = v.wr_a; wr_data = v.wr_d;
        for (int cyc = 1; cyc <= 25; cyc++) begin
            @(negedge clk);
            if (rd_ack && rd_ack_cyc == 0) begin
                rd_ack_cyc = cyc;
                rd_req = 1'b0;
            end
            if (wr_ack && wr_ack_cyc == 0) begin
                wr_ack_cyc = cyc;
                wr_req = 1'b0;
            end
            if (mem_en && !mem_we) begin
                a = 16'(v.rd_a + n_iss);
                chk($sformatf("v%0d_rd_addr%0d", idx, n_iss), mem_addr, a);
                chk($sformatf("v%0d_rd_iss_cyc%0d", idx, n_iss), cyc, 2 + n_iss);
                n_iss++;
            end
            if (mem_en && mem_we) begin
                chk($sformatf("v%0d_wr_addr", idx), mem_addr, v.wr_a);
                chk($sformatf("v%0d_wr_data", idx), mem_wdata, v.wr_d);
                chk($sformatf("v%0d_wr_ack_with_we", idx), wr_ack, 1);
                n_wr++;
            end
            if (rd_valid) begin
                a = 16'(v.rd_a + n_val);
                chk($sformatf("v%0d_rd_data%0d", idx, n_val), rd_data, exp_mem[a]);
                chk($sformatf("v%0d_rd_valid_cyc%0d", idx, n_val), cyc, 3 + n_val);
                chk($sformatf("v%0d_rd_last%0d", idx, n_val), rd_last, (n_val == BL - 1));
                n_val++;
            end else if (rd_last) begin
                chk($sformatf("v%0d_last_without_valid", idx), rd_last, 0);
            end
        end
        chk($sformatf("v%0d_rd_ack_cyc", idx), rd_ack_cyc, v.exp_rd_ack);
        chk($sformatf("v%0d_wr_ack_cyc", idx), wr_ack_cyc, v.exp_wr_ack);
        chk($sformatf("v%0d_n_issue", idx), n_iss, v.do_rd ? BL : 0);
        chk($sformatf("v%0d_n_valid", idx), n_val, v.do_rd ? BL : 0);
        chk($sformatf("v%0d_n_write", idx), n_wr, v.do_wr ? 1 : 0);
        chk($sformatf("v%0d_busy_end", idx), busy, 0);
        if (v.do_wr) exp_mem[v.wr_a] = v.wr_d;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_ack;
        int ack_cyc [3];
        int last_rd_ack, wr_cyc, n_iss;
        logic rd_on;

        for (int i = 0; i < 65536; i++) begin
            ram[i]     = 16'(i) ^ 16'hA5A5;
            exp_mem[i] = 16'(i) ^ 16'hA5A5;
        end

        vecs[0] = '{1'b1, 16'h0100, 1'b0, 16'h0000, 16'h0000, 1, 0};
        vecs[1] = '{1'b1, 16'hFFFC, 1'b0, 16'h0000, 16'h0000, 1, 0};
        vecs[2] = '{1'b0, 16'h0000, 1'b1, 16'h0103, 16'hBEEF, 0, 2};
        vecs[3] = '{1'b1, 16'h0100, 1'b1, 16'h2000, 16'h1234, 1, 11};
        vecs[4] = '{1'b1, 16'h1FFC, 1'b0, 16'h0000, 16'h0000, 1, 0};

        // reset and idle
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_rd_valid", rd_valid, 0);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("idle_ctrl%0d", c),
                {rd_ack, rd_valid, rd_last, wr_ack, mem_en, mem_we, busy}, 0);
            chk($sformatf("idle_data%0d", c), {mem_addr, mem_wdata, rd_data}, 0);
        end

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // back-to-back bursts with rd_req held
        rd_req = 1'b1; rd_addr = 16'h0600; n_ack = 0;
        for (int cyc = 1; cyc <= 40 && n_ack < 3; cyc++) begin
            @(negedge clk);
            if (rd_ack) begin
                ack_cyc[n_ack] = cyc;
                n_ack++;
                if (n_ack == 3) rd_req = 1'b0;
            end
        end
        rd_req = 1'b0;
        chk("b2b_n_ack", n_ack, 3);
        chk("b2b_ack0", ack_cyc[0], 1);
        chk("b2b_ack1", ack_cyc[1], 1 + BL + 1);
        chk("b2b_ack2", ack_cyc[2], 1 + 2 * (BL + 1));
        repeat (15) @(negedge clk);

        // writer behind a display that never lets go
        rd_req = 1'b1; rd_addr = 16'h4000; rd_on = 1'b1;
        wr_req = 1'b1; wr_addr = 16'h3000; wr_data = 16'h5555;
        last_rd_ack = 0; wr_cyc = 0;
        for (int cyc = 1; cyc <= 150 && (rd_on || wr_req); cyc++) begin
            @(negedge clk);
            if (wr_ack && wr_cyc == 0) begin
                wr_cyc = cyc;
                wr_req = 1'b0;
            end
            if (rd_ack && rd_on) begin
                last_rd_ack = cyc;
                if (cyc > 40 || wr_cyc != 0) begin
                    rd_req = 1'b0;
                    rd_on  = 1'b0;
                end
            end
        end
        rd_req = 1'b0; wr_req = 1'b0;
`ifdef FB_ARB_STARVE_GUARD_EN
        chk("starve_wr_granted", (wr_cyc > 0), 1);
        chk("starve_wr_bound", (wr_cyc <= 64 + BL + 2), 1);
`else
        chk("prio_rd_dropped_late", (last_rd_ack > 40), 1);
        chk("prio_wr_after_drop", wr_cyc, last_rd_ack + BL + 2);
`endif
        exp_mem[16'h3000] = 16'h5555;
        repeat (15) @(negedge clk);

        // reset asserted on the 4th beat of a burst
        rd_req = 1'b1; rd_addr = 16'h0500; n_iss = 0;
        for (int cyc = 1; cyc <= 20 && n_iss < 4; cyc++) begin
            @(negedge clk);
            if (rd_ack) rd_req = 1'b0;
            if (mem_en && !mem_we) n_iss++;
        end
        rd_req = 1'b0;
        chk("rstmid_reached_beat4", n_iss, 4);
        rst_n = 1'b0;
        #1;
        chk("rstmid_valid", rd_valid, 0);
        chk("rstmid_last", rd_last, 0);
        chk("rstmid_en", mem_en, 0);
        chk("rstmid_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("rstmid_quiet%0d", c),
                {rd_ack, rd_valid, rd_last, wr_ack, mem_en, busy}, 0);
        end

        // data readback after the reset, including earlier writes
        run_vec('{1'b1, 16'h00FE, 1'b0, 16'h0000, 16'h0000, 1, 0}, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
